// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Read-side master for the synchronous FIFO. It issues fifo_rd_en against
//   fifo_empty, absorbs the FIFO's one-cycle registered read latency, and
//   re-presents the words as a valid/ready stream through a 2-entry skid
//   buffer. Handshaken output words are counted.
//
// Ports:
//   clk            clock, all state updates on posedge
//   rstN           asynchronous active-low reset
//   enable         1 = new FIFO reads may be issued
//   fifo_empty     FIFO empty flag
//   fifo_data_out  FIFO read data, valid the cycle after fifo_rd_en sampled
//   fifo_rd_en     FIFO read request (combinational)
//   m_valid        output word valid
//   m_data         output word (head of the skid buffer)
//   m_ready        downstream accepts when m_valid & m_ready
//   rd_count       number of handshaken words, wraps modulo 2^CNT_WIDTH
//   idle           no buffered words and no read in flight
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  idle
);

    // Skid-buffer occupancy; entry0 is the head.
    typedef enum logic [1:0] {
        OCC_0 = 2'd0,
        OCC_1 = 2'd1,
        OCC_2 = 2'd2
    } occ_t;

    occ_t                  r_occ;
    occ_t                  w_occ_next;
    logic                  r_inflight;
    logic [FIFO_WIDTH-1:0] r_entry0;
    logic [FIFO_WIDTH-1:0] r_entry1;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  w_pop;
    logic                  w_cap_sel1;

    // Occupancy next-state is occ + inflight - pop. Because occ + inflight
    // never exceeds 2, requesting a read only when that sum stays below 2
    // guarantees every in-flight word has a free slot when it lands.
    always_comb begin
        w_pop      = (r_occ != OCC_0) & m_ready;
        w_occ_next = r_occ;
        w_cap_sel1 = 1'b0;
        case (r_occ)
            OCC_0: begin
                if (r_inflight) w_occ_next = OCC_1;
            end
            OCC_1: begin
                if (r_inflight && !w_pop) begin
                    w_occ_next = OCC_2;
                    w_cap_sel1 = 1'b1;
                end else if (!r_inflight && w_pop) begin
                    w_occ_next = OCC_0;
                end
            end
            OCC_2: begin
                w_cap_sel1 = 1'b1;
                if (w_pop) w_occ_next = OCC_1;
            end
            default: w_occ_next = OCC_0;
        endcase
        // rstN gates the request so no read is issued while held in reset.
        fifo_rd_en = rstN & enable & ~fifo_empty & (w_occ_next != OCC_2);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_occ      <= OCC_0;
            r_inflight <= 1'b0;
            r_count    <= '0;
        end else begin
            r_occ      <= w_occ_next;
            r_inflight <= fifo_rd_en;
            if (w_pop) r_count <= r_count + CNT_WIDTH'(1);
        end
    end

    // Shift on pop, then capture; the capture target already accounts for
    // the shift (entry0 when the buffer is or becomes empty, else entry1).
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_entry0 <= '0;
            r_entry1 <= '0;
        end else begin
            if (w_pop) r_entry0 <= r_entry1;
            if (r_inflight) begin
                if (w_cap_sel1) r_entry1 <= fifo_data_out;
                else            r_entry0 <= fifo_data_out;
            end
        end
    end

    assign m_valid  = (r_occ != OCC_0);
    assign m_data   = r_entry0;
    assign rd_count = r_count;
    assign idle     = (r_occ == OCC_0) & ~r_inflight;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader. A behavioural synchronous FIFO
//   (registered read data) feeds two DUT copies sharing all inputs: dut0 with
//   the default counter width and dut1 with a 4-bit counter for the wrap case.
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rstN;
    logic        enable;
    logic        m_ready;
    logic        fifo_empty;
    logic [7:0]  fifo_data_out = '0;

    logic        fifo_rd_en, m_valid, idle;
    logic [7:0]  m_data;
    logic [15:0] rd_count;

    logic        rd_en1, m_valid1, idle1;
    logic [7:0]  m_data1;
    logic [3:0]  rd_count1;

    // FIFO model
    logic        f_wr = 1'b0;
    logic [7:0]  f_wdata = '0;
    logic [7:0]  f_mem [0:31];
    logic [4:0]  f_wp = '0;
    logic [4:0]  f_rp = '0;
    logic [5:0]  f_cnt = '0;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          got;
    logic        exp_rd, exp_v;
    logic        occ_bad = 1'b0;

    always #5 clk = ~clk;

    assign fifo_empty = (f_cnt == 6'd0);

    always @(posedge clk) begin
        if (f_wr) begin
            f_mem[f_wp] <= f_wdata;
            f_wp        <= f_wp + 5'd1;
        end
        if (fifo_rd_en) begin
            fifo_data_out <= f_mem[f_rp];
            f_rp          <= f_rp + 5'd1;
        end
        f_cnt <= f_cnt + 6'(f_wr) - 6'(fifo_rd_en);
    end

    always @(negedge clk) begin
        if (int'(dut0.r_occ) + int'(dut0.r_inflight) > 2 ||
            int'(dut1.r_occ) + int'(dut1.r_inflight) > 2)
            occ_bad <= 1'b1;
    end

    fifo_stream_reader #(.FIFO_WIDTH(8), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rstN(rstN), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(fifo_rd_en),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .rd_count(rd_count), .idle(idle)
    );

    fifo_stream_reader #(.FIFO_WIDTH(8), .CNT_WIDTH(4)) dut1 (
        .clk(clk), .rstN(rstN), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_data_out(fifo_data_out), .fifo_rd_en(rd_en1),
        .m_valid(m_valid1), .m_data(m_data1), .m_ready(m_ready),
        .rd_count(rd_count1), .idle(idle1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] base, input int unsigned n);
        f_wr = 1'b1;
        for (int unsigned i = 0; i < n; i++) begin
            f_wdata = base + 8'(i);
            step();
        end
        f_wr = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0; enable = 1'b0; m_ready = 1'b0;
        #12;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
        n_cmp++; if (rd_count !== 16'd0) begin n_bad++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got=%b exp=1", idle); end
        n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
        step();
        rstN = 1'b1; enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL post_reset_rd_en cyc=%0d got=%b exp=0", i, fifo_rd_en); end
            n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_m_valid cyc=%0d got=%b exp=0", i, m_valid); end
            n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL post_reset_idle cyc=%0d got=%b exp=1", i, idle); end
            step();
        end
    endtask

    task automatic test_streaming();
        enable = 1'b0; m_ready = 1'b1;
        preload(8'h01, 5);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            exp_rd = (i < 5);
            exp_v  = (i >= 2 && i < 7);
            n_cmp++; if (fifo_rd_en !== exp_rd) begin n_bad++; $display("FAIL stream_rd_en cyc=%0d got=%b exp=%b", i, fifo_rd_en, exp_rd); end
            n_cmp++; if (m_valid !== exp_v) begin n_bad++; $display("FAIL stream_m_valid cyc=%0d got=%b exp=%b", i, m_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (m_data !== 8'(i - 1)) begin n_bad++; $display("FAIL stream_m_data cyc=%0d got=%h exp=%h", i, m_data, 8'(i - 1)); end
            end
            step();
        end
        n_cmp++; if (rd_count !== 16'd5) begin n_bad++; $display("FAIL stream_rd_count got=%0d exp=5", rd_count); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL stream_idle got=%b exp=1", idle); end
    endtask

    task automatic test_backpressure();
        enable = 1'b0; m_ready = 1'b0;
        preload(8'h10, 8);
        enable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_rd = (i < 2);
            n_cmp++; if (fifo_rd_en !== exp_rd) begin n_bad++; $display("FAIL bp_rd_en cyc=%0d got=%b exp=%b", i, fifo_rd_en, exp_rd); end
            if (i >= 2) begin
                n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL bp_m_valid cyc=%0d got=%b exp=1", i, m_valid); end
                n_cmp++; if (m_data !== 8'h10) begin n_bad++; $display("FAIL bp_m_data_stable cyc=%0d got=%h exp=10", i, m_data); end
            end
            step();
        end
        got = 0;
        for (int t = 0; t < 40 && got < 8; t++) begin
            m_ready = (t % 2 == 0);
            #1;
            if (m_valid && m_ready) begin
                n_cmp++; if (m_data !== 8'h10 + 8'(got)) begin n_bad++; $display("FAIL bp_order word=%0d got=%h exp=%h", got, m_data, 8'h10 + 8'(got)); end
                got++;
            end
            step();
        end
        n_cmp++; if (got !== 8) begin n_bad++; $display("FAIL bp_word_count got=%0d exp=8", got); end
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup cyc=%0d got=%b exp=0", i, m_valid); end
            step();
        end
        n_cmp++; if (rd_count !== 16'd13) begin n_bad++; $display("FAIL bp_rd_count got=%0d exp=13", rd_count); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL bp_idle got=%b exp=1", idle); end
        n_cmp++; if (occ_bad !== 1'b0) begin n_bad++; $display("FAIL bp_occ_bound got=%b exp=0", occ_bad); end
    endtask

    task automatic test_empty_guard();
        enable = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL empty_rd_en cyc=%0d got=%b exp=0", i, fifo_rd_en); end
            step();
        end
        f_wr = 1'b1; f_wdata = 8'hA5;
        #1;
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL empty_rd_en_wr got=%b exp=0", fifo_rd_en); end
        step();
        f_wr = 1'b0;
        #1;
        n_cmp++; if (fifo_rd_en !== 1'b1) begin n_bad++; $display("FAIL empty_rd_pulse got=%b exp=1", fifo_rd_en); end
        step();
        #1;
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL empty_single_pulse got=%b exp=0", fifo_rd_en); end
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL empty_latency got=%b exp=0", m_valid); end
        n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL empty_inflight_idle got=%b exp=0", idle); end
        step();
        #1;
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL empty_m_valid got=%b exp=1", m_valid); end
        n_cmp++; if (m_data !== 8'hA5) begin n_bad++; $display("FAIL empty_m_data got=%h exp=a5", m_data); end
        step();
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL empty_after got=%b exp=0", m_valid); end
        n_cmp++; if (rd_count !== 16'd14) begin n_bad++; $display("FAIL empty_rd_count got=%0d exp=14", rd_count); end
        step();
    endtask

    task automatic test_enable_drop();
        enable = 1'b0; m_ready = 1'b1;
        preload(8'h20, 16);
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 4) enable = 1'b0;
            #1;
            exp_rd = (i < 4);
            exp_v  = (i >= 2 && i < 6);
            n_cmp++; if (fifo_rd_en !== exp_rd) begin n_bad++; $display("FAIL endrop_rd_en cyc=%0d got=%b exp=%b", i, fifo_rd_en, exp_rd); end
            n_cmp++; if (m_valid !== exp_v) begin n_bad++; $display("FAIL endrop_m_valid cyc=%0d got=%b exp=%b", i, m_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (m_data !== 8'h20 + 8'(i - 2)) begin n_bad++; $display("FAIL endrop_m_data cyc=%0d got=%h exp=%h", i, m_data, 8'h20 + 8'(i - 2)); end
            end
            step();
        end
        enable = 1'b1;
        for (int r = 0; r < 16; r++) begin
            #1;
            exp_rd = (r < 12);
            exp_v  = (r >= 2 && r < 14);
            n_cmp++; if (fifo_rd_en !== exp_rd) begin n_bad++; $display("FAIL resume_rd_en cyc=%0d got=%b exp=%b", r, fifo_rd_en, exp_rd); end
            n_cmp++; if (m_valid !== exp_v) begin n_bad++; $display("FAIL resume_m_valid cyc=%0d got=%b exp=%b", r, m_valid, exp_v); end
            if (exp_v) begin
                n_cmp++; if (m_data !== 8'h24 + 8'(r - 2)) begin n_bad++; $display("FAIL resume_m_data cyc=%0d got=%h exp=%h", r, m_data, 8'h24 + 8'(r - 2)); end
            end
            step();
        end
        n_cmp++; if (rd_count !== 16'd30) begin n_bad++; $display("FAIL endrop_rd_count got=%0d exp=30", rd_count); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL endrop_idle got=%b exp=1", idle); end
    endtask

    task automatic test_reset_midstream();
        enable = 1'b0; m_ready = 1'b0;
        preload(8'h30, 2);
        enable = 1'b1;
        step(); step(); step();
        #1;
        n_cmp++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre_m_valid got=%b exp=1", m_valid); end
        n_cmp++; if (m_data !== 8'h30) begin n_bad++; $display("FAIL mid_pre_m_data got=%h exp=30", m_data); end
        #1;
        rstN = 1'b0;
        #1;
        n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset_m_valid got=%b exp=0", m_valid); end
        n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL mid_reset_rd_en got=%b exp=0", fifo_rd_en); end
        n_cmp++; if (rd_count !== 16'd0) begin n_bad++; $display("FAIL mid_reset_rd_count got=%0d exp=0", rd_count); end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_reset_idle got=%b exp=1", idle); end
        n_cmp++; if (m_data !== 8'h00) begin n_bad++; $display("FAIL mid_reset_m_data got=%h exp=00", m_data); end
        step(); step();
        rstN = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (fifo_rd_en !== 1'b0) begin n_bad++; $display("FAIL mid_release_rd_en cyc=%0d got=%b exp=0", i, fifo_rd_en); end
            n_cmp++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL mid_release_m_valid cyc=%0d got=%b exp=0", i, m_valid); end
            n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL mid_release_idle cyc=%0d got=%b exp=1", i, idle); end
            step();
        end
    endtask

    task automatic test_counter_wrap();
        enable = 1'b0; m_ready = 1'b1;
        preload(8'h40, 17);
        enable = 1'b1;
        for (int i = 0; i < 21; i++) begin
            #1;
            exp_rd = (i < 17);
            exp_v  = (i >= 2 && i < 19);
            n_cmp++; if (rd_en1 !== exp_rd) begin n_bad++; $display("FAIL wrap_rd_en cyc=%0d got=%b exp=%b", i, rd_en1, exp_rd); end
            n_cmp++; if (m_valid1 !== exp_v) begin n_bad++; $display("FAIL wrap_m_valid cyc=%0d got=%b exp=%b", i, m_valid1, exp_v); end
            if (exp_v) begin
                n_cmp++; if (m_data1 !== 8'h40 + 8'(i - 2)) begin n_bad++; $display("FAIL wrap_m_data cyc=%0d got=%h exp=%h", i, m_data1, 8'h40 + 8'(i - 2)); end
            end
            if (i == 17) begin
                n_cmp++; if (rd_count1 !== 4'd15) begin n_bad++; $display("FAIL wrap_count15 got=%0d exp=15", rd_count1); end
            end
            if (i == 18) begin
                n_cmp++; if (rd_count1 !== 4'd0) begin n_bad++; $display("FAIL wrap_count16 got=%0d exp=0", rd_count1); end
            end
            if (i == 19) begin
                n_cmp++; if (rd_count1 !== 4'd1) begin n_bad++; $display("FAIL wrap_count17 got=%0d exp=1", rd_count1); end
            end
            if (i == 20) begin
                n_cmp++; if (rd_count !== 16'd17) begin n_bad++; $display("FAIL wrap_wide_count got=%0d exp=17", rd_count); end
                n_cmp++; if (idle1 !== 1'b1) begin n_bad++; $display("FAIL wrap_idle got=%b exp=1", idle1); end
            end
            step();
        end
        n_cmp++; if (occ_bad !== 1'b0) begin n_bad++; $display("FAIL final_occ_bound got=%b exp=0", occ_bad); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty_guard();
        test_enable_drop();
        test_reset_midstream();
        test_counter_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Read-side master for the team's synchronous FIFO. It drives rd_en against the FIFO's empty flag and absorbs the FIFO's one-cycle registered read latency. It re-presents the data as a valid/ready stream with a 2-entry skid buffer, so it sustains one word per clock under downstream backpressure without losing or duplicating words. It sits between the FIFO read port and any downstream consumer, and also counts delivered words.

Parameters:
FIFO_WIDTH, 8, data width of the FIFO and of the output stream
CNT_WIDTH, 16, width of the delivered-word counter

Ports:
clk  input  1  clock; all state updates on posedge
rstN  input  1  asynchronous active-low reset
enable  input  1  1 = permitted to issue new FIFO reads
fifo_empty  input  1  FIFO empty flag
fifo_data_out  input  FIFO_WIDTH  FIFO read data, valid the cycle after rd_en sampled high
fifo_rd_en  output  1  FIFO read request
m_valid  output  1  output stream word valid
m_data  output  FIFO_WIDTH  output stream data
m_ready  input  1  downstream accepts word when m_valid & m_ready
rd_count  output  CNT_WIDTH  number of handshaken output words, wraps modulo 2^CNT_WIDTH
idle  output  1  1 = no words buffered and no read in flight

Behaviour:
- Reset (rstN low, async): fifo_rd_en=0, m_valid=0, m_data=0, rd_count=0, idle=1. Buffer occupancy and the in-flight flag are cleared. Any in-flight FIFO read is discarded; the word it popped is lost, which is accepted.
- State:
  - occ (0..2) = skid-buffer entries; entry0 is the head.
  - inflight (1 bit) = registered copy of fifo_rd_en from the previous cycle.
- pop = m_valid & m_ready.
- fifo_rd_en (combinational) = enable & ~fifo_empty & ((occ + inflight - pop) < 2). It must never be high while fifo_empty=1.
- Capture: when inflight=1, fifo_data_out is written at the next edge.
  - Target entry = occ - pop: entry0 if the buffer is empty or the head is being popped with occ=1; otherwise entry1.
- Pop: entry1 shifts to entry0 on the same edge. Pop and capture on the same edge is legal: occ_next = occ + inflight - pop.
- Outputs:
  - m_valid = (occ != 0), registered.
  - m_data = entry0.
  - While m_valid=1 and m_ready=0, m_data holds stable.
- Latency: rd_en sampled at edge E0 → word in buffer and m_valid=1 after edge E1 (m_valid high 2 edges after first rd_en cycle when occ was 0).
- Throughput: with m_ready=1 and FIFO non-empty, steady state is occ=1, inflight=1, one read and one pop per cycle.
- Overflow impossible by construction: occ + inflight ≤ 2 always. Reaching occ=3 is a design error, and verification asserts against it.
- enable deasserted: no new rd_en. In-flight and buffered words still drain to the output normally. Re-asserting enable resumes reads with no gap beyond the credit rule.
- rd_count increments by 1 on each pop and wraps from all-ones to 0.
- idle = (occ==0) & (inflight==0).
- Word order at m_data equals FIFO read order exactly.

Test Plan:
- Reset: assert rstN=0 mid-stream with occ=2 → immediately m_valid=0, fifo_rd_en=0, rd_count=0, idle=1. After release with FIFO empty, outputs stay at reset values.
- Streaming: FIFO preloaded 0x01..0x05, enable=1, m_ready=1 → fifo_rd_en high 5 consecutive cycles. m_valid rises 2 edges after first rd_en, then delivers 0x01..0x05 on 5 consecutive cycles. rd_count=5, idle=1 afterwards.
- Backpressure: FIFO holds 0x10..0x17, m_ready=0 → exactly 2 rd_en pulses, then rd_en=0; m_data=0x10 stable. Toggle m_ready 1/0 every cycle → all 8 words delivered in order, no duplicates, occ never >2.
- Empty guard: fifo_empty=1 for 20 cycles with enable=1 → fifo_rd_en never asserted. Write one word 0xA5 → single rd_en pulse, then m_valid with m_data=0xA5.
- Enable drop: streaming 0x20..0x2F, deassert enable after 4th rd_en → no further rd_en. Words already read (up to 4) still delivered. Re-assert enable → delivery resumes at the next word with no loss.
- Counter wrap: CNT_WIDTH=4, stream 17 words → rd_count reads 15 after the 15th word and 0 after the 16th; after the 17th it reads 1.
